bcd_modn_counter: RTL and testbench

BCD_MODN_COUNTER -- requirements
Module: bcd_modn_counter

---
 rtl/bcd_cnt_pkg.sv | 33 +++
 rtl/bcd_modn_counter_if.sv | 29 ++
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_modn_counter.sv | 100 ++++++++++
 tb/tb_bcd_modn_counter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared constants, types and elaboration helpers for the BCD modulo-N counter.
// Contents: BCD_W digit width, bcd_digit_t, pow10() and int_to_bcd() used only
// for parameter checks and constant generation.
package bcd_cnt_pkg;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned MAX_DIGITS = 4;
   localparam int unsigned MAX_W      = BCD_W * MAX_DIGITS;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   // 10**n, used to bound MODULUS against the digit count.
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // Integer to packed BCD, digit 0 in bits [3:0]; evaluated at elaboration only.
   function automatic logic [MAX_W-1:0] int_to_bcd(input int unsigned val);
      logic [MAX_W-1:0] res;
      int unsigned      v;
      res = '0;
      v   = val;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         res[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
         v = v / 10;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_modn_counter_if.sv
// Control/data bundle for bcd_modn_counter.
// master: drives clr, load, load_val, en, up; observes q, tc, load_err.
// slave : the counter side.
interface bcd_modn_counter_if
   import bcd_cnt_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) ();

   logic                    clr;
   logic                    load;
   logic [BCD_W*DIGITS-1:0] load_val;
   logic                    en;
   logic                    up;
   logic [BCD_W*DIGITS-1:0] q;
   logic                    tc;
   logic                    load_err;

   modport master (
      output clr, load, load_val, en, up,
      input  q, tc, load_err
   );

   modport slave (
      input  clr, load, load_val, en, up,
      output q, tc, load_err
   );

endinterface

// File: rtl/bcd_digit.sv
// One decade cell: steps a single BCD digit up or down when step is set.
// Ports: cur (present digit), step (carry/borrow in), up (direction),
//        nxt (next digit), cout (carry on 9->0 / borrow on 0->9).
// Modulus wrap is not handled here; the top level overrides the chain.
module bcd_digit
   import bcd_cnt_pkg::*;
(
   input  bcd_digit_t cur,
   input  logic       step,
   input  logic       up,
   output bcd_digit_t nxt,
   output logic       cout
);

   always_comb begin
      nxt  = cur;
      cout = 1'b0;
      if (step) begin
         if (up) begin
            if (cur == BCD_W'(9)) begin
               nxt  = '0;
               cout = 1'b1;
            end else begin
               nxt = cur + BCD_W'(1);
            end
         end else begin
            if (cur == '0) begin
               nxt  = BCD_W'(9);
               cout = 1'b1;
            end else begin
               nxt = cur - BCD_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/bcd_modn_counter.sv
// Up/down BCD counter over 0..MODULUS-1 with clear, validated load and wrap pulse.
// Ports: clk, rst (async active-high), bus (slave modport: clr, load, load_val,
//        en, up in; q, tc, load_err out -- all outputs registered).
module bcd_modn_counter
   import bcd_cnt_pkg::*;
#(
   parameter int unsigned DIGITS  = 2,
   parameter int unsigned MODULUS = 24
) (
   input logic               clk,
   input logic               rst,
   bcd_modn_counter_if.slave bus
);

   localparam int unsigned  W        = BCD_W * DIGITS;
   localparam logic [W-1:0] TERM_BCD = W'(int_to_bcd(MODULUS - 1));

   // Parameter legality
   if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
      $fatal(1, "bcd_modn_counter: DIGITS=%0d outside 1..4", DIGITS);
   end
   if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
      $fatal(1, "bcd_modn_counter: MODULUS=%0d outside 2..10**DIGITS", MODULUS);
   end

   logic [W-1:0]    q_q, q_d;
   logic            tc_q, tc_d;
   logic            err_q, err_d;
   logic [W-1:0]    chain_c;
   logic [DIGITS:0] cy_c;
   logic            load_ok_c;

   // Decimal increment/decrement chain; digit 0 always steps.
   assign cy_c[0] = 1'b1;
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
         .cur  (q_q[i*BCD_W +: BCD_W]),
         .step (cy_c[i]),
         .up   (bus.up),
         .nxt  (chain_c[i*BCD_W +: BCD_W]),
         .cout (cy_c[i+1])
      );
   end

   // With every digit <= 9, packed BCD orders like the integer, so a plain
   // vector compare against the BCD terminal checks the value range.
   always_comb begin
      load_ok_c = (bus.load_val <= TERM_BCD);
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bus.load_val[i*BCD_W +: BCD_W] > BCD_W'(9)) load_ok_c = 1'b0;
      end
   end

   // Next state: clr > load > en. A borrow out of the top digit means q was 0.
   always_comb begin
      q_d   = q_q;
      tc_d  = 1'b0;
      err_d = 1'b0;
      if (bus.clr) begin
         q_d = '0;
      end else if (bus.load) begin
         if (load_ok_c) q_d   = bus.load_val;
         else           err_d = 1'b1;
      end else if (bus.en) begin
         if (bus.up) begin
            if (q_q == TERM_BCD) begin
               q_d  = '0;
               tc_d = 1'b1;
            end else begin
               q_d = chain_c;
            end
         end else begin
            if (cy_c[DIGITS]) begin
               q_d  = TERM_BCD;
               tc_d = 1'b1;
            end else begin
               q_d = chain_c;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= '0;
         tc_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         tc_q  <= tc_d;
         err_q <= err_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.tc       = tc_q;
   assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: three instances (2-digit mod 24, 3-digit mod 1000,
// 1-digit mod 2) compared every cycle against an integer reference model.
module tb_bcd_modn_counter;

   typedef struct {
      bit          c;
      bit          l;
      bit          e;
      bit          u;
      logic [15:0] lv;
   } stim_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_modn_counter_if #(.DIGITS(2)) ifa ();
   bcd_modn_counter_if #(.DIGITS(3)) ifb ();
   bcd_modn_counter_if #(.DIGITS(1)) ifc ();

   bcd_modn_counter #(.DIGITS(2), .MODULUS(24))   u_a (.clk(clk), .rst(rst), .bus(ifa));
   bcd_modn_counter #(.DIGITS(3), .MODULUS(1000)) u_b (.clk(clk), .rst(rst), .bus(ifb));
   bcd_modn_counter #(.DIGITS(1), .MODULUS(2))    u_c (.clk(clk), .rst(rst), .bus(ifc));

   int          vectors    = 0;
   int          miscompares = 0;
   int unsigned a_val, b_val, c_val;
   stim_t       sa, sb, sc;

   function automatic logic [15:0] int2bcd(input int unsigned n);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] v, input int unsigned nd);
      for (int unsigned i = 0; i < nd; i++)
         if (v[i*4 +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int unsigned bcd2int(input logic [15:0] v, input int unsigned nd);
      int unsigned s, w;
      s = 0;
      w = 1;
      for (int unsigned i = 0; i < nd; i++) begin
         s = s + 32'(v[i*4 +: 4]) * w;
         w = w * 10;
      end
      return s;
   endfunction

   // Integer-level behaviour of one counter for one clock edge.
   task automatic model(input int unsigned m, input int unsigned nd, input stim_t s,
                        inout int unsigned val, output bit tc, output bit err);
      tc  = 1'b0;
      err = 1'b0;
      if (s.c) val = 0;
      else if (s.l) begin
         if (bcd_ok(s.lv, nd) && bcd2int(s.lv, nd) < m) val = bcd2int(s.lv, nd);
         else err = 1'b1;
      end else if (s.e) begin
         if (s.u) begin
            if (val == m - 1) begin val = 0; tc = 1'b1; end
            else val = val + 1;
         end else begin
            if (val == 0) begin val = m - 1; tc = 1'b1; end
            else val = val - 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply current stimulus to all instances, clock once, check all three.
   task automatic tick_all(input string tag);
      bit          tc, err;
      logic [15:0] e;
      ifa.clr = sa.c; ifa.load = sa.l; ifa.en = sa.e; ifa.up = sa.u; ifa.load_val = sa.lv[7:0];
      ifb.clr = sb.c; ifb.load = sb.l; ifb.en = sb.e; ifb.up = sb.u; ifb.load_val = sb.lv[11:0];
      ifc.clr = sc.c; ifc.load = sc.l; ifc.en = sc.e; ifc.up = sc.u; ifc.load_val = sc.lv[3:0];
      @(posedge clk);
      #1;
      model(24, 2, sa, a_val, tc, err);
      e = int2bcd(a_val);
      chk({tag, "_a"}, {ifa.q, ifa.tc, ifa.load_err}, {e[7:0], tc, err});
      model(1000, 3, sb, b_val, tc, err);
      e = int2bcd(b_val);
      chk({tag, "_b"}, {ifb.q, ifb.tc, ifb.load_err}, {e[11:0], tc, err});
      model(2, 1, sc, c_val, tc, err);
      e = int2bcd(c_val);
      chk({tag, "_c"}, {ifc.q, ifc.tc, ifc.load_err}, {e[3:0], tc, err});
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.c = 0; s.l = 0; s.e = 0; s.u = 0; s.lv = '0;
      return s;
   endfunction

   function automatic stim_t mk(input bit c, input bit l, input logic [15:0] lv,
                                input bit e, input bit u);
      stim_t s;
      s.c = c; s.l = l; s.e = e; s.u = u; s.lv = lv;
      return s;
   endfunction

   initial begin
      sa = idle(); sb = idle(); sc = idle();
      ifa.clr = 0; ifa.load = 0; ifa.en = 0; ifa.up = 0; ifa.load_val = '0;
      ifb.clr = 0; ifb.load = 0; ifb.en = 0; ifb.up = 0; ifb.load_val = '0;
      ifc.clr = 0; ifc.load = 0; ifc.en = 0; ifc.up = 0; ifc.load_val = '0;
      a_val = 0; b_val = 0; c_val = 0;

      // Reset takes effect before any clock edge
      rst = 1'b1;
      #2;
      chk("reset_a", {ifa.q, ifa.tc, ifa.load_err}, 32'h0);
      chk("reset_b", {ifb.q, ifb.tc, ifb.load_err}, 32'h0);
      chk("reset_c", {ifc.q, ifc.tc, ifc.load_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Full up cycle of the mod-24 counter
      sa = mk(0, 0, 0, 1, 1);
      for (int i = 1; i <= 24; i++) begin
         tick_all("up24");
         chk("up24_tc", 32'(ifa.tc), (i == 24) ? 32'd1 : 32'd0);
      end
      chk("up24_end", 32'(ifa.q), 32'h00);

      // Decrement with borrow, and underflow wrap
      sa = mk(0, 1, 16'h10, 0, 0); tick_all("ld10");
      sa = mk(0, 0, 0, 1, 0);      tick_all("dn10");
      chk("dn10_q", 32'(ifa.q), 32'h09);
      sa = mk(1, 0, 0, 0, 0);      tick_all("clr");
      sa = mk(0, 0, 0, 1, 0);      tick_all("dn00");
      chk("dn00_q", {ifa.q, ifa.tc}, {8'h23, 1'b1});

      // Rejected and accepted loads
      sa = mk(0, 1, 16'h07, 0, 0); tick_all("ld07");
      sa = mk(0, 1, 16'h25, 0, 0); tick_all("ld25");
      chk("ld25_err", {ifa.q, ifa.load_err}, {8'h07, 1'b1});
      sa = idle();                 tick_all("idle1");
      chk("ld25_pulse", 32'(ifa.load_err), 32'd0);
      sa = mk(0, 1, 16'h1A, 0, 0); tick_all("ld1a");
      chk("ld1a_err", {ifa.q, ifa.load_err}, {8'h07, 1'b1});
      sa = mk(0, 1, 16'h19, 0, 0); tick_all("ld19");
      chk("ld19_q", {ifa.q, ifa.load_err}, {8'h19, 1'b0});

      // Priority clr > load > en
      sa = mk(1, 1, 16'h12, 1, 1); tick_all("prio_clr");
      chk("prio_clr_q", 32'(ifa.q), 32'h00);
      sa = mk(0, 1, 16'h12, 1, 1); tick_all("prio_ld");
      chk("prio_ld_q", 32'(ifa.q), 32'h12);

      // Asynchronous reset between edges, then normal first edge
      sa = mk(0, 1, 16'h17, 0, 0); tick_all("ld17");
      sa = idle();
      #2 rst = 1'b1;
      #1;
      chk("arst_a", {ifa.q, ifa.tc, ifa.load_err}, 32'h0);
      #1 rst = 1'b0;
      a_val = 0; b_val = 0; c_val = 0;
      sa = mk(0, 0, 0, 1, 1);      tick_all("post_rst");
      chk("post_rst_q", 32'(ifa.q), 32'h01);
      sa = idle();

      // 3-digit full carry wrap
      sb = mk(0, 1, 16'h999, 0, 0); tick_all("b_ld999");
      sb = mk(0, 0, 0, 1, 1);       tick_all("b_wrap");
      chk("b_wrap_q", {ifb.q, ifb.tc}, {12'h000, 1'b1});
      sb = idle();

      // Mod-2 with en held: tc on every 1->0 edge
      sc = mk(0, 0, 0, 1, 1);
      for (int i = 1; i <= 6; i++) begin
         tick_all("c_tog");
         chk("c_tog_q", {ifc.q, ifc.tc}, (i % 2 == 1) ? {4'h1, 1'b0} : {4'h0, 1'b1});
      end

      // Randomized traffic on all three instances
      for (int n = 0; n < 400; n++) begin
         sa.c  = ($urandom_range(0, 15) == 0);
         sa.l  = ($urandom_range(0, 5) == 0);
         sa.e  = ($urandom_range(0, 3) != 0);
         sa.u  = 1'($urandom_range(0, 1));
         sa.lv = $urandom_range(0, 1) ? int2bcd($urandom_range(0, 29)) : 16'($urandom_range(0, 255));
         sb.c  = ($urandom_range(0, 31) == 0);
         sb.l  = ($urandom_range(0, 7) == 0);
         sb.e  = ($urandom_range(0, 3) != 0);
         sb.u  = 1'($urandom_range(0, 1));
         sb.lv = $urandom_range(0, 1) ? int2bcd($urandom_range(0, 999)) : 16'($urandom_range(0, 4095));
         sc.c  = ($urandom_range(0, 15) == 0);
         sc.l  = ($urandom_range(0, 5) == 0);
         sc.e  = ($urandom_range(0, 3) != 0);
         sc.u  = 1'($urandom_range(0, 1));
         sc.lv = 16'($urandom_range(0, 11));
         tick_all("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
